// File: rtl/write_buffer_ctrl_if.sv
// Producer / RAM / read-side signal bundle for the write buffer controller.
interface write_buffer_ctrl_if #(
    parameter int unsigned width      = 7,
    parameter int unsigned addr_width = 4
);
    logic [width:0]        data_in;
    logic                  WriteReq;
    logic                  WriteAck;
    logic                  ReadDone;
    logic [width:0]        ram_data;
    logic [addr_width-1:0] ram_addr;
    logic                  ram_we;
    logic                  Full;
    logic                  Empty;
    logic [addr_width:0]   count;

    // Environment side: producer, read side and RAM observer
    modport master (
        output data_in, WriteReq, ReadDone,
        input  WriteAck, ram_data, ram_addr, ram_we, Full, Empty, count
    );

    // Controller side
    modport slave (
        input  data_in, WriteReq, ReadDone,
        output WriteAck, ram_data, ram_addr, ram_we, Full, Empty, count
    );
endinterface

// File: rtl/write_buffer_ctrl.sv
// Write-side FIFO controller: four-phase producer handshake into a buffer
// register, one-cycle RAM commit, write pointer and occupancy tracking.
module write_buffer_ctrl #(
    parameter int unsigned width      = 7,
    parameter int unsigned addr_width = 4
) (
    input  logic                clk,
    input  logic                Clear,
    write_buffer_ctrl_if.slave  bus
);
    localparam int unsigned DATA_W = width + 1;
    localparam int unsigned CNT_W  = addr_width + 1;
    localparam int unsigned DEPTH  = 2 ** addr_width;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     buf_q, buf_d;
    logic [addr_width-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_c;
    logic                  inc_c;
    logic                  dec_c;

    assign full_c = (count_q == CNT_W'(DEPTH));

    // State, buffer and pointer registers; Clear wipes everything at once
    always_ff @(posedge clk or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            buf_q   <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Handshake sequencing: accept only when not full, commit for one cycle
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        wptr_d  = wptr_q;
        inc_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.WriteReq && !full_c) begin
                    buf_d   = bus.data_in;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wptr_d  = addr_width'(wptr_q + 1'b1);
                inc_c   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!bus.WriteReq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy: a commit and a consume in the same cycle cancel out
    always_comb begin
        dec_c   = bus.ReadDone && (count_q != '0);
        count_d = count_q;
        if (inc_c && !dec_c) begin
            count_d = CNT_W'(count_q + 1'b1);
        end else if (dec_c && !inc_c) begin
            count_d = CNT_W'(count_q - 1'b1);
        end
    end

    assign bus.ram_we   = (state_q == WRITE);
    assign bus.WriteAck = (state_q == ACK);
    assign bus.ram_data = buf_q;
    assign bus.ram_addr = wptr_q;
    assign bus.count    = count_q;
    assign bus.Full     = full_c;
    assign bus.Empty    = (count_q == '0);
endmodule
